elevator_car_sequencer: RTL and testbench
=========================================

// Module: elevator_car_sequencer
// PURPOSE
//  Read-side consumer of the per-floor elevator request queue (one bit per floor).
//  Scans queue_status with a SCAN policy, moves the car one floor per TRAVEL_CYCLES
//  and opens the door at each requested floor.
//  On arrival it issues a one-cycle clear write (q_r_nwr=0, q_deassert=1, q_floor) to the queue.
//  Sits inside the elevator car between the request queue and the motor/door drivers.
// PARAMETERS
//  FLOOR_COUNT    7   number of floors; queue bit i = floor i
//  FLOOR_W        3   floor index width; must satisfy 2**FLOOR_W >= FLOOR_COUNT
//  TRAVEL_CYCLES  16  clk cycles per one-floor hop (>=2)
//  DOOR_CYCLES    32  clk cycles door_open stays high per stop (>=2)
// PORTS
//  clk            in   1            clock, rising edge
//  reset          in   1            reset, asynchronous, active-high
//  queue_status   in   FLOOR_COUNT  pending requests from queue; 1 = floor requested
//  q_r_nwr        out  1            queue access: 1 = read/no-op, 0 = write
//  q_deassert     out  1            1 with q_r_nwr=0 clears bit q_floor
//  q_floor        out  FLOOR_W      floor index for queue write; always = current_floor
//  current_floor  out  FLOOR_W      car position
//  direction      out  2            00 idle, 01 up, 10 down (11 never driven)
//  moving         out  1            high while in MOVING
//  door_open      out  1            high while in DOOR
//  door_hold      in   1            [DOOR_HOLD_EN only] extend door open
// BEHAVIOUR
//  - All outputs registered (Moore). Reset, asynchronous: state=IDLE, current_floor=0,
//    direction=00, last_dir=UP, moving=0, door_open=0, q_r_nwr=1, q_deassert=0, q_floor=0,
//    counters=0. Reset mid-travel or mid-door takes effect immediately; the car re-homes to floor 0.
//  - States: IDLE, MOVING, CLEAR, DOOR.
//  - IDLE:
//    - If queue_status[current_floor] -> CLEAR.
//    - Else if requests exist above and below -> continue last_dir.
//    - Else go toward the only side with requests; set direction and last_dir, load hop counter = TRAVEL_CYCLES-1, enter MOVING.
//    - No requests -> stay; direction=00.
//  - MOVING: the counter decrements each cycle. At counter==0, current_floor +/-1 on that edge, then:
//    - Request bit at the new floor -> CLEAR.
//    - Else a request exists further in direction -> reload counter, stay MOVING.
//    - Else -> IDLE. This covers bits cleared externally and the top/bottom floor.
//  - Floor movement never goes below 0 or above FLOOR_COUNT-1.
//  - A bit set mid-travel at a not-yet-reached floor in the travel direction causes a stop there.
//  - CLEAR: exactly 1 cycle with q_r_nwr=0, q_deassert=1, q_floor=current_floor.
//    Next state DOOR; load door counter = DOOR_CYCLES-1. In all other states q_r_nwr=1 and q_deassert=0.
//  - DOOR: door_open=1 and the counter decrements each cycle; direction keeps its value.
//    - queue_status[current_floor] is ignored during the first cycle of DOOR (queue write latency).
//    - If that bit reads 1 later in DOOR -> back to CLEAR (door stays open, timer restarts).
//    - At counter==0 -> IDLE, door_open=0; IDLE re-evaluates the queue.
//  - Latency: request at floor k from idle floor f (k!=f): MOVING entered 1 cycle after the bit is seen.
//    Arrival after |k-f|*TRAVEL_CYCLES cycles, then 1 CLEAR cycle, then DOOR_CYCLES door cycles.
//  - Simultaneous: new requests and counter expiry are sampled on the same edge; the new bits count.
// CONFIGURATION
//  - DOOR_HOLD_EN defined:
//    - door_hold port exists. While door_hold=1 in DOOR, the door counter reloads to DOOR_CYCLES-1, so the door cannot close.
//    - door_open drops DOOR_CYCLES cycles after door_hold falls.
//    - door_hold is ignored in other states.
//  - DOOR_HOLD_EN undefined: no door_hold port; the door always closes DOOR_CYCLES cycles after CLEAR.
// TESTING (bench models the queue: bit cleared one edge after q_r_nwr=0 and q_deassert=1)
//  1. Reset, queue=7'b0000100 -> direction=01; current_floor 1 at +16, 2 at +32.
//     Then 1-cycle q_r_nwr=0/q_deassert=1/q_floor=2, door_open high 32 cycles, then direction=00.
//  2. Car idle at 3, last_dir=UP, queue=7'b0100010 -> stops at 5 first, then travels down and stops at 1.
//  3. Idle at 0, queue=7'b0000001 -> CLEAR next cycle, moving never asserts, door_open 32 cycles.
//  4. Moving 0->4; bit 2 set while current_floor=1 -> stops and clears at 2, then continues to 4.
//  5. Assert reset while moving between floors 2 and 3 -> outputs take reset values immediately;
//     after release, current_floor=0 and direction=00.
//  6. [DOOR_HOLD_EN] door_hold=1 for 100 cycles during DOOR -> door_open stays high until 32 cycles after door_hold falls.

Source files
------------

// File: rtl/elevator_car_sequencer_if.sv
// Request-queue access bundle between the car sequencer (master) and the
// per-floor request queue (slave): status read path plus the clear-write strobe.
interface elevator_car_sequencer_if #(
    parameter int FLOOR_COUNT = 7,
    parameter int FLOOR_W     = 3
);
    logic [FLOOR_COUNT-1:0] queue_status;
    logic                   q_r_nwr;
    logic                   q_deassert;
    logic [FLOOR_W-1:0]     q_floor;

    modport master (
        input  queue_status,
        output q_r_nwr,
        output q_deassert,
        output q_floor
    );

    modport slave (
        output queue_status,
        input  q_r_nwr,
        input  q_deassert,
        input  q_floor
    );
endinterface

// File: rtl/elevator_car_sequencer.sv
// Elevator car sequencer: SCAN-policy consumer of the per-floor request queue.
// Moves the car one floor per TRAVEL_CYCLES, clears the served request with a
// one-cycle queue write and holds the door open for DOOR_CYCLES.
// All outputs are registered from the next-state logic (Moore).
// Optional feature macro: DOOR_HOLD_EN adds the door_hold input, which keeps
// the door timer reloaded while asserted during DOOR.
module elevator_car_sequencer #(
    parameter int FLOOR_COUNT   = 7,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    elevator_car_sequencer_if.master     qbus,
`ifdef DOOR_HOLD_EN
    input  logic                         door_hold,
`endif
    output logic [FLOOR_W-1:0]           current_floor,
    output logic [1:0]                   direction,
    output logic                         moving,
    output logic                         door_open
);

    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0]   HOP_LOAD  = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOOR_COUNT - 1);

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_MOVING, S_CLEAR, S_DOOR} state_t;

    state_t               r_state,  w_state_nxt;
    logic [FLOOR_W-1:0]   r_floor,  w_floor_nxt;
    logic [1:0]           r_dir,    w_dir_nxt;
    logic                 r_last_up, w_last_up_nxt;
    logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
    logic                 r_door_first, w_door_first_nxt;
    logic                 r_moving, r_door_open, r_q_r_nwr, r_q_deassert;

    logic [FLOOR_W-1:0]   w_step_floor;
    logic                 w_req_here, w_req_above, w_req_below, w_go_up;
    logic                 w_step_here, w_step_beyond;

    // Request bit at floor f (floors outside the queue read as no request).
    function automatic logic req_at(input logic [FLOOR_COUNT-1:0] qs, input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++)
            if (i == int'(f)) hit = qs[i];
        return hit;
    endfunction

    // Any request strictly above floor f.
    function automatic logic req_above(input logic [FLOOR_COUNT-1:0] qs, input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++)
            if (i > int'(f)) hit = hit | qs[i];
        return hit;
    endfunction

    // Any request strictly below floor f.
    function automatic logic req_below(input logic [FLOOR_COUNT-1:0] qs, input logic [FLOOR_W-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++)
            if (i < int'(f)) hit = hit | qs[i];
        return hit;
    endfunction

    assign w_req_here  = req_at(qbus.queue_status, r_floor);
    assign w_req_above = req_above(qbus.queue_status, r_floor);
    assign w_req_below = req_below(qbus.queue_status, r_floor);
    // With requests on both sides keep sweeping the way we last went.
    assign w_go_up     = (w_req_above && w_req_below) ? r_last_up : w_req_above;

    // Floor reached at the end of the current hop, clamped to the shaft ends.
    assign w_step_floor = (r_dir == DIR_UP) ? ((r_floor < TOP_FLOOR) ? r_floor + FLOOR_W'(1) : r_floor)
                                            : ((r_floor != '0)       ? r_floor - FLOOR_W'(1) : r_floor);
    assign w_step_here   = req_at(qbus.queue_status, w_step_floor);
    assign w_step_beyond = (r_dir == DIR_UP) ? req_above(qbus.queue_status, w_step_floor)
                                             : req_below(qbus.queue_status, w_step_floor);

    // Next-state and next-datapath decisions for the SCAN sequencer.
    always_comb begin
        w_state_nxt      = r_state;
        w_floor_nxt      = r_floor;
        w_dir_nxt        = r_dir;
        w_last_up_nxt    = r_last_up;
        w_cnt_nxt        = r_cnt;
        w_door_first_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_dir_nxt = DIR_IDLE;
                if (w_req_here) begin
                    w_state_nxt = S_CLEAR;
                end else if (w_req_above || w_req_below) begin
                    w_state_nxt   = S_MOVING;
                    w_dir_nxt     = w_go_up ? DIR_UP : DIR_DN;
                    w_last_up_nxt = w_go_up;
                    w_cnt_nxt     = HOP_LOAD;
                end
            end
            S_MOVING: begin
                if (r_cnt == '0) begin
                    w_floor_nxt = w_step_floor;
                    if (w_step_here) begin
                        w_state_nxt = S_CLEAR;
                    end else if (w_step_beyond) begin
                        w_cnt_nxt = HOP_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_dir_nxt   = DIR_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_CLEAR: begin
                w_state_nxt      = S_DOOR;
                w_cnt_nxt        = DOOR_LOAD;
                w_door_first_nxt = 1'b1;
            end
            S_DOOR: begin
                // The first door cycle still sees the bit we just cleared.
                if (!r_door_first && w_req_here) begin
                    w_state_nxt = S_CLEAR;
`ifdef DOOR_HOLD_EN
                end else if (door_hold) begin
                    w_cnt_nxt = DOOR_LOAD;
`endif
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_dir_nxt   = DIR_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered Moore outputs; asynchronous reset re-homes the car.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_floor      <= '0;
            r_dir        <= DIR_IDLE;
            r_last_up    <= 1'b1;
            r_cnt        <= '0;
            r_door_first <= 1'b0;
            r_moving     <= 1'b0;
            r_door_open  <= 1'b0;
            r_q_r_nwr    <= 1'b1;
            r_q_deassert <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_floor      <= w_floor_nxt;
            r_dir        <= w_dir_nxt;
            r_last_up    <= w_last_up_nxt;
            r_cnt        <= w_cnt_nxt;
            r_door_first <= w_door_first_nxt;
            r_moving     <= (w_state_nxt == S_MOVING);
            r_door_open  <= (w_state_nxt == S_DOOR);
            r_q_r_nwr    <= (w_state_nxt != S_CLEAR);
            r_q_deassert <= (w_state_nxt == S_CLEAR);
        end
    end

    assign current_floor   = r_floor;
    assign direction       = r_dir;
    assign moving          = r_moving;
    assign door_open       = r_door_open;
    assign qbus.q_r_nwr    = r_q_r_nwr;
    assign qbus.q_deassert = r_q_deassert;
    assign qbus.q_floor    = r_floor;

endmodule

// File: tb/tb_elevator_car_sequencer.sv
// Directed bench for elevator_car_sequencer with a behavioural request queue:
// a bit is cleared one edge after the car shows q_r_nwr=0 / q_deassert=1.
// Build with DOOR_HOLD_EN defined to exercise the door-hold feature too.
module tb_elevator_car_sequencer;

    localparam int FC = 7;
    localparam int FW = 3;
    localparam int TC = 16;
    localparam int DC = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [FC-1:0] q_bits;
    logic [FW-1:0] current_floor;
    logic [1:0]    direction;
    logic          moving;
    logic          door_open;
`ifdef DOOR_HOLD_EN
    logic          door_hold;
`endif

    int errors = 0;
    int checks = 0;

    elevator_car_sequencer_if #(.FLOOR_COUNT(FC), .FLOOR_W(FW)) qif ();
    assign qif.queue_status = q_bits;

    elevator_car_sequencer #(
        .FLOOR_COUNT(FC), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .qbus(qif.master),
`ifdef DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .current_floor(current_floor),
        .direction(direction),
        .moving(moving),
        .door_open(door_open)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; the queue model applies any pending clear write at the edge.
    task automatic tick();
        logic          clr;
        logic [FW-1:0] f;
        clr = !qif.q_r_nwr && qif.q_deassert;
        f   = qif.q_floor;
        @(posedge clk);
        #1;
        if (clr) q_bits[f] = 1'b0;
    endtask

    // Wait for the clear write, check the floor, then time the door.
    task automatic serve(input string tag, input int fl);
        int n;
        n = 0;
        while (!(qif.q_deassert && !qif.q_r_nwr) && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, int'(n < 400), 1);
        check({tag, "_floor"}, current_floor, fl);
        check({tag, "_qfloor"}, qif.q_floor, fl);
        n = 0;
        tick();
        while (door_open && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_door_len"}, n, DC);
    endtask

    task automatic wait_floor(input string tag, input int fl);
        int n;
        n = 0;
        while (current_floor != fl && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, current_floor, fl);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset  = 1'b1;
        q_bits = '0;
`ifdef DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        tick();
        tick();
        check("rst_floor", current_floor, 0);
        check("rst_dir", direction, 0);
        check("rst_moving", moving, 0);
        check("rst_door", door_open, 0);
        check("rst_rnwr", qif.q_r_nwr, 1);
        check("rst_deassert", qif.q_deassert, 0);
        check("rst_qfloor", qif.q_floor, 0);
        reset = 1'b0;
        tick();

        // 1: single request two floors up, exact timing
        q_bits = 7'b0000100;
        tick();
        check("t1_dir", direction, 1);
        check("t1_moving", moving, 1);
        repeat (TC - 1) tick();
        check("t1_still0", current_floor, 0);
        tick();
        check("t1_floor1", current_floor, 1);
        repeat (TC - 1) tick();
        check("t1_still1", current_floor, 1);
        tick();
        check("t1_floor2", current_floor, 2);
        check("t1_rnwr", qif.q_r_nwr, 0);
        check("t1_deassert", qif.q_deassert, 1);
        check("t1_qfloor", qif.q_floor, 2);
        check("t1_moving_off", moving, 0);
        tick();
        check("t1_door_on", door_open, 1);
        check("t1_rnwr_back", qif.q_r_nwr, 1);
        n = 1;
        while (door_open && n < 200) begin
            tick();
            if (door_open) n++;
        end
        check("t1_door_len", n, DC);
        check("t1_dir_idle", direction, 0);

        // 2: idle at 3 going up, requests at 5 and 1
        q_bits = 7'b0001000;
        serve("t2pre", 3);
        q_bits = 7'b0100010;
        tick();
        check("t2_dir_up", direction, 1);
        serve("t2a", 5);
        check("t2_dir_idle", direction, 0);
        tick();
        check("t2_dir_down", direction, 2);
        serve("t2b", 1);

        // 3: request at the current floor
        q_bits = 7'b0000001;
        serve("t3pre", 0);
        q_bits = 7'b0000001;
        tick();
        check("t3_clear_now", qif.q_deassert, 1);
        check("t3_moving", moving, 0);
        check("t3_dir", direction, 0);
        serve("t3", 0);

        // 4: request added mid-travel ahead of the car
        q_bits = 7'b0010000;
        wait_floor("t4_at1", 1);
        q_bits[2] = 1'b1;
        serve("t4a", 2);
        serve("t4b", 4);

        // 5: asynchronous reset between floors 3 and 2
        q_bits = 7'b0000001;
        wait_floor("t5_at3", 3);
        repeat (5) tick();
        check("t5_moving_pre", moving, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_floor", current_floor, 0);
        check("t5_dir", direction, 0);
        check("t5_moving", moving, 0);
        check("t5_rnwr", qif.q_r_nwr, 1);
        q_bits = '0;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("t5_post_floor", current_floor, 0);
        check("t5_post_dir", direction, 0);

`ifdef DOOR_HOLD_EN
        // 6: door hold keeps the door open
        q_bits = 7'b0000001;
        tick();
        check("t6_clear", qif.q_deassert, 1);
        tick();
        door_hold = 1'b1;
        repeat (100) tick();
        check("t6_held", door_open, 1);
        door_hold = 1'b0;
        n = 0;
        while (door_open && n < 200) begin
            tick();
            n++;
        end
        check("t6_release_len", n, DC);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
